// File: rtl/pll_lock_rst_seq.sv
// Power-up sequencer: pulses the memory PLL reset, waits for stable lock, then releases DDR3 and system resets.
// Optional macro PLL_LOCK_RST_SEQ_CALIB_TIMEOUT_EN bounds the calibration wait and retries from DDRRST.
module pll_lock_rst_seq #(
  parameter int PLL_RST_CYCLES       = 16,
  parameter int LOCK_STABLE_CYCLES   = 1024,
  parameter int DDR_RST_CYCLES       = 256,
  parameter int LOCK_TIMEOUT_CYCLES  = 65535,
  parameter int CALIB_TIMEOUT_CYCLES = 1000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       pll_lock,
  input  logic       init_calib_complete,
  output logic       pll_rst,
  output logic       ddr_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic [2:0] state,
  output logic [7:0] retry_cnt,
  output logic [7:0] lock_loss_cnt
);

  typedef enum logic [2:0] {
    S_PLLRST   = 3'd0,
    S_WAITLOCK = 3'd1,
    S_STABLE   = 3'd2,
    S_DDRRST   = 3'd3,
    S_CALIB    = 3'd4,
    S_RUN      = 3'd5
  } state_t;

  // Every dwell limit must fit the shared 20-bit counter.
  if (PLL_RST_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || DDR_RST_CYCLES < 1 ||
      LOCK_TIMEOUT_CYCLES < 1 || CALIB_TIMEOUT_CYCLES < 1 ||
      PLL_RST_CYCLES > 1048576 || LOCK_STABLE_CYCLES > 1048576 || DDR_RST_CYCLES > 1048576 ||
      LOCK_TIMEOUT_CYCLES > 1048576 || CALIB_TIMEOUT_CYCLES > 1048576) begin : g_param_check
    $error("pll_lock_rst_seq: cycle parameters must lie in 1..2^20");
  end

  localparam logic [19:0] L_PLL_RST_LAST = 20'(PLL_RST_CYCLES - 1);
  localparam logic [19:0] L_STABLE_LAST  = 20'(LOCK_STABLE_CYCLES - 1);
  localparam logic [19:0] L_DDR_RST_LAST = 20'(DDR_RST_CYCLES - 1);
  localparam logic [19:0] L_LOCK_TO_LAST = 20'(LOCK_TIMEOUT_CYCLES - 1);
`ifdef PLL_LOCK_RST_SEQ_CALIB_TIMEOUT_EN
  localparam logic [19:0] L_CALIB_TO_LAST = 20'(CALIB_TIMEOUT_CYCLES - 1);
`endif

  function automatic logic [7:0] sat_inc8(input logic [7:0] v, input logic inc);
    if (inc && v != 8'hFF) return v + 8'd1;
    return v;
  endfunction

  // Returns {pll_rst, ddr_rst, sys_rst, ready} for a state.
  function automatic logic [3:0] decode_out(input state_t s);
    logic run, cal;
    run = (s == S_RUN);
    cal = (s == S_CALIB);
    return {s == S_PLLRST, !(cal || run), !run, run};
  endfunction

  logic   r_lock_p0, r_lock_p1;
  logic   r_cal_p0, r_cal_p1;
  state_t r_state;
  logic [19:0] r_cnt;

  state_t w_nxt;
  logic   w_retry_inc;
  logic   w_loss_inc;
  logic [3:0] w_out;

  always_comb begin
    w_nxt       = r_state;
    w_retry_inc = 1'b0;
    w_loss_inc  = 1'b0;
    case (r_state)
      S_PLLRST: begin
        if (r_cnt == L_PLL_RST_LAST) w_nxt = S_WAITLOCK;
      end
      S_WAITLOCK: begin
        if (r_lock_p1) begin
          w_nxt = S_STABLE;
        end else if (r_cnt == L_LOCK_TO_LAST) begin
          w_nxt       = S_PLLRST;
          w_retry_inc = 1'b1;
        end
      end
      S_STABLE: begin
        if (!r_lock_p1)                   w_nxt = S_WAITLOCK;
        else if (r_cnt == L_STABLE_LAST)  w_nxt = S_DDRRST;
      end
      S_DDRRST: begin
        if (!r_lock_p1)                   w_nxt = S_PLLRST;
        else if (r_cnt == L_DDR_RST_LAST) w_nxt = S_CALIB;
      end
      S_CALIB: begin
        // Lock loss outranks a calibration edge arriving in the same cycle.
        if (!r_lock_p1) begin
          w_nxt = S_PLLRST;
        end else if (r_cal_p1) begin
          w_nxt = S_RUN;
        end
`ifdef PLL_LOCK_RST_SEQ_CALIB_TIMEOUT_EN
        else if (r_cnt == L_CALIB_TO_LAST) begin
          w_nxt       = S_DDRRST;
          w_retry_inc = 1'b1;
        end
`endif
      end
      S_RUN: begin
        if (!r_lock_p1) begin
          w_nxt      = S_PLLRST;
          w_loss_inc = 1'b1;
        end else if (!r_cal_p1) begin
          w_nxt = S_DDRRST;
        end
      end
      default: w_nxt = S_PLLRST;
    endcase
  end

  assign w_out = decode_out(w_nxt);

  // Stage p0/p1: input synchronizers; state, counter and outputs register together.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lock_p0     <= 1'b0;
      r_lock_p1     <= 1'b0;
      r_cal_p0      <= 1'b0;
      r_cal_p1      <= 1'b0;
      r_state       <= S_PLLRST;
      r_cnt         <= '0;
      pll_rst       <= 1'b1;
      ddr_rst       <= 1'b1;
      sys_rst       <= 1'b1;
      ready         <= 1'b0;
      retry_cnt     <= '0;
      lock_loss_cnt <= '0;
    end else begin
      r_lock_p0     <= pll_lock;
      r_lock_p1     <= r_lock_p0;
      r_cal_p0      <= init_calib_complete;
      r_cal_p1      <= r_cal_p0;
      r_state       <= w_nxt;
      r_cnt         <= (w_nxt != r_state) ? 20'd0 : r_cnt + 20'd1;
      pll_rst       <= w_out[3];
      ddr_rst       <= w_out[2];
      sys_rst       <= w_out[1];
      ready         <= w_out[0];
      retry_cnt     <= sat_inc8(retry_cnt, w_retry_inc);
      lock_loss_cnt <= sat_inc8(lock_loss_cnt, w_loss_inc);
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_pll_lock_rst_seq.sv
// Bench for pll_lock_rst_seq: directed vector table, multi-cycle corner sequences and a randomized run
// compared every cycle against a dwell-time reference model.
module tb_pll_lock_rst_seq;

  localparam int PR = 4, LS = 8, DR = 6, LT = 20, CT = 30;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       pll_lock = 1'b0;
  logic       init_calib_complete = 1'b0;
  logic       pll_rst, ddr_rst, sys_rst, ready;
  logic [2:0] state;
  logic [7:0] retry_cnt, lock_loss_cnt;

  always #5 clk = ~clk;

  pll_lock_rst_seq #(
    .PLL_RST_CYCLES(PR), .LOCK_STABLE_CYCLES(LS), .DDR_RST_CYCLES(DR),
    .LOCK_TIMEOUT_CYCLES(LT), .CALIB_TIMEOUT_CYCLES(CT)
  ) dut (
    .clk(clk), .rst(rst), .pll_lock(pll_lock), .init_calib_complete(init_calib_complete),
    .pll_rst(pll_rst), .ddr_rst(ddr_rst), .sys_rst(sys_rst), .ready(ready),
    .state(state), .retry_cnt(retry_cnt), .lock_loss_cnt(lock_loss_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase name as code, time spent in phase, inputs seen two edges late.
  int   m_st, m_age, m_retry, m_loss;
  logic q_lk[$];
  logic q_cal[$];

  function automatic logic [22:0] expect_of(input int st, input int rt, input int ll);
    logic [2:0] s;
    s = 3'(st);
    return {s, st == 0, !(st == 4 || st == 5), st != 5, st == 5, 8'(rt), 8'(ll)};
  endfunction

  task automatic check_vec(input string nm, input logic [22:0] exp);
    logic [22:0] got;
    got = {state, pll_rst, ddr_rst, sys_rst, ready, retry_cnt, lock_loss_cnt};
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got st=%0d pll/ddr/sys/rdy=%b retry=%0d loss=%0d, want st=%0d pll/ddr/sys/rdy=%b retry=%0d loss=%0d",
               nm, got[22:20], got[19:16], got[15:8], got[7:0], exp[22:20], exp[19:16], exp[15:8], exp[7:0]);
    end
  endtask

  task automatic model_step(input logic lk, input logic cal, input logic r);
    logic elk, ecal;
    int   nxt;
    if (r) begin
      m_st = 0; m_age = 0; m_retry = 0; m_loss = 0;
      q_lk = {1'b0, 1'b0};
      q_cal = {1'b0, 1'b0};
      return;
    end
    elk  = q_lk.pop_front();
    ecal = q_cal.pop_front();
    q_lk.push_back(lk);
    q_cal.push_back(cal);
    nxt = m_st;
    if (m_st == 0) begin
      if (m_age + 1 == PR) nxt = 1;
    end else if (m_st == 1) begin
      if (elk) nxt = 2;
      else if (m_age + 1 == LT) begin nxt = 0; m_retry = (m_retry < 255) ? m_retry + 1 : 255; end
    end else if (m_st == 2) begin
      if (!elk) nxt = 1;
      else if (m_age + 1 == LS) nxt = 3;
    end else if (m_st == 3) begin
      if (!elk) nxt = 0;
      else if (m_age + 1 == DR) nxt = 4;
    end else if (m_st == 4) begin
      if (!elk) nxt = 0;
      else if (ecal) nxt = 5;
`ifdef PLL_LOCK_RST_SEQ_CALIB_TIMEOUT_EN
      else if (m_age + 1 == CT) begin nxt = 3; m_retry = (m_retry < 255) ? m_retry + 1 : 255; end
`endif
    end else if (m_st == 5) begin
      if (!elk) begin nxt = 0; m_loss = (m_loss < 255) ? m_loss + 1 : 255; end
      else if (!ecal) nxt = 3;
    end else begin
      nxt = 0;
    end
    m_age = (nxt == m_st) ? m_age + 1 : 0;
    m_st  = nxt;
  endtask

  // Called at a negedge: drive inputs, let one posedge pass, compare at the next negedge.
  task automatic cyc(input logic lk, input logic cal, input logic r);
    pll_lock = lk;
    init_calib_complete = cal;
    rst = r;
    @(posedge clk);
    model_step(lk, cal, r);
    @(negedge clk);
    check_vec("model", expect_of(m_st, m_retry, m_loss));
  endtask

  typedef struct {
    logic       r, lk, cal;
    int         n;
    logic [2:0] st;
    logic       pll, ddr, sys, rdy;
    logic [7:0] retry, loss;
  } vec_t;

  function automatic vec_t mk(input logic r, input logic lk, input logic cal, input int n,
                              input logic [2:0] st, input logic pll, input logic ddr,
                              input logic sys, input logic rdy, input logic [7:0] rt,
                              input logic [7:0] ll);
    vec_t v;
    v.r = r; v.lk = lk; v.cal = cal; v.n = n; v.st = st;
    v.pll = pll; v.ddr = ddr; v.sys = sys; v.rdy = rdy; v.retry = rt; v.loss = ll;
    return v;
  endfunction

  vec_t tbl[13];

  initial begin
    logic lk_v, cal_v;
    int   pct[4];

    // Nominal bring-up, lock loss in RUN, then reset mid-operation.
    tbl[0]  = mk(1, 0, 0,  2, 3'd0, 1, 1, 1, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 10, 3'd1, 0, 1, 1, 0, 0, 0);
    tbl[2]  = mk(0, 1, 0,  3, 3'd2, 0, 1, 1, 0, 0, 0);
    tbl[3]  = mk(0, 1, 0,  8, 3'd3, 0, 1, 1, 0, 0, 0);
    tbl[4]  = mk(0, 1, 0,  6, 3'd4, 0, 0, 1, 0, 0, 0);
    tbl[5]  = mk(0, 1, 0,  5, 3'd4, 0, 0, 1, 0, 0, 0);
    tbl[6]  = mk(0, 1, 1,  2, 3'd4, 0, 0, 1, 0, 0, 0);
    tbl[7]  = mk(0, 1, 1,  1, 3'd5, 0, 0, 0, 1, 0, 0);
    tbl[8]  = mk(0, 1, 1,  5, 3'd5, 0, 0, 0, 1, 0, 0);
    tbl[9]  = mk(0, 0, 1,  2, 3'd5, 0, 0, 0, 1, 0, 0);
    tbl[10] = mk(0, 0, 1,  1, 3'd0, 1, 1, 1, 0, 0, 1);
    tbl[11] = mk(0, 0, 0,  1, 3'd0, 1, 1, 1, 0, 0, 1);
    tbl[12] = mk(1, 0, 0,  1, 3'd0, 1, 1, 1, 0, 0, 0);

    @(negedge clk);
    for (int i = 0; i < 13; i++) begin
      for (int k = 0; k < tbl[i].n; k++) cyc(tbl[i].lk, tbl[i].cal, tbl[i].r);
      check_vec($sformatf("vec%0d", i),
                {tbl[i].st, tbl[i].pll, tbl[i].ddr, tbl[i].sys, tbl[i].rdy, tbl[i].retry, tbl[i].loss});
    end

    // Lock glitch seen at STABLE counter 5 forces a fresh 8-cycle stable window.
    cyc(1, 0, 1);
    for (int k = 0; k < 8; k++) cyc(1, 0, 0);
    cyc(0, 0, 0);
    cyc(1, 0, 0);
    check_vec("glitch_pre", expect_of(2, 0, 0));
    cyc(1, 0, 0);
    check_vec("glitch_back", expect_of(1, 0, 0));
    for (int k = 0; k < 8; k++) cyc(1, 0, 0);
    check_vec("glitch_restable", expect_of(2, 0, 0));
    cyc(1, 0, 0);
    check_vec("glitch_ddrrst", expect_of(3, 0, 0));

    // No lock for 100 cycles: PLL reset re-pulses every 24 cycles.
    cyc(0, 0, 1);
    for (int k = 1; k <= 100; k++) begin
      cyc(0, 0, 0);
      if (k == 23) check_vec("timeout_before", expect_of(1, 0, 0));
      if (k == 24) check_vec("timeout_first", expect_of(0, 1, 0));
    end
    check_vec("timeout_four", expect_of(1, 4, 0));

    // Calibration never arrives.
    cyc(1, 0, 1);
    for (int k = 0; k < 19; k++) cyc(1, 0, 0);
    check_vec("calib_enter", expect_of(4, 0, 0));
`ifdef PLL_LOCK_RST_SEQ_CALIB_TIMEOUT_EN
    for (int k = 0; k < 29; k++) cyc(1, 0, 0);
    check_vec("calib_last", expect_of(4, 0, 0));
    cyc(1, 0, 0);
    check_vec("calib_timeout", expect_of(3, 1, 0));
`else
    for (int k = 0; k < 1000; k++) cyc(1, 0, 0);
    check_vec("calib_wait", expect_of(4, 0, 0));
`endif

    // Lock loss and calibration rising together in CALIB.
    cyc(1, 0, 1);
    for (int k = 0; k < 19; k++) cyc(1, 0, 0);
    cyc(0, 1, 0);
    cyc(0, 1, 0);
    check_vec("simul_hold", expect_of(4, 0, 0));
    cyc(0, 1, 0);
    check_vec("simul_pllrst", expect_of(0, 0, 0));

    // 300 lock losses from RUN saturate the loss counter.
    cyc(1, 1, 1);
    for (int it = 0; it < 300; it++) begin
      for (int k = 0; k < 20; k++) cyc(1, 1, 0);
      if (it == 0) check_vec("loss_run", expect_of(5, 0, 0));
      for (int k = 0; k < 3; k++) cyc(0, 1, 0);
      if (it == 0) check_vec("loss_one", expect_of(0, 0, 1));
    end
    check_vec("loss_sat", expect_of(0, 0, 255));

    // Randomized phases with varying lock quality and occasional reset.
    pct[0] = 70; pct[1] = 97; pct[2] = 99; pct[3] = 100;
    lk_v = 1'b0;
    cal_v = 1'b0;
    cyc(0, 0, 1);
    for (int ph = 0; ph < 4; ph++) begin
      for (int k = 0; k < 800; k++) begin
        lk_v = ($urandom_range(99, 0) < pct[ph]);
        if ($urandom_range(99, 0) < 8) cal_v = ~cal_v;
        cyc(lk_v, cal_v, ($urandom_range(999, 0) < 3));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pll_lock_rst_seq.md
PLL_LOCK_RST_SEQ -- requirements
Module: pll_lock_rst_seq

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 16: cycles `pll_rst` is held high per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024: consecutive cycles `pll_lock` must stay high before release.
REQ-003 SHALL have parameter DDR_RST_CYCLES, default 256: cycles `ddr_rst` is held after stable lock.
REQ-004 SHALL have parameter LOCK_TIMEOUT_CYCLES, default 65535: cycles to wait for lock before re-pulsing the PLL reset.
REQ-005 SHALL have parameter CALIB_TIMEOUT_CYCLES, default 1000000: calibration wait limit, used only under CALIB_TIMEOUT_EN.
REQ-006 SHALL have port `clk`, input, 1 bit: free-running 27 MHz board clock; the only clock.
REQ-007 SHALL have port `rst`, input, 1 bit: synchronous, active-high reset.
REQ-008 SHALL have port `pll_lock`, input, 1 bit: lock output of the memory PLL, asynchronous to `clk`.
REQ-009 SHALL have port `init_calib_complete`, input, 1 bit: calibration-done flag from the DDR3 controller, asynchronous.
REQ-010 SHALL have port `pll_rst`, output, 1 bit: drives the PLL RESET input.
REQ-011 SHALL have port `ddr_rst`, output, 1 bit: active-high reset to the DDR3 controller.
REQ-012 SHALL have port `sys_rst`, output, 1 bit: active-high reset to the video/user logic.
REQ-013 SHALL have port `ready`, output, 1 bit: high only in RUN.
REQ-014 SHALL have port `state`, output, 3 bits: current state code.
REQ-015 SHALL have port `retry_cnt`, output, 8 bits: saturating count of timeout retries.
REQ-016 SHALL have port `lock_loss_cnt`, output, 8 bits: saturating count of lock losses while in RUN.

Function
REQ-017 SHALL pass `pll_lock` and `init_calib_complete` through two-flop synchronizers; all decisions below use the synchronized values, adding 2 cycles of input latency.
REQ-018 SHALL implement states PLLRST=0, WAITLOCK=1, STABLE=2, DDRRST=3, CALIB=4, RUN=5; codes 6-7 SHALL go to PLLRST on the next cycle.
REQ-019 SHALL use one shared 20-bit cycle counter, cleared on every state entry and incremented each cycle within a state.
REQ-020 PLLRST: SHALL go to WAITLOCK when counter = PLL_RST_CYCLES-1.
REQ-021 WAITLOCK: SHALL go to STABLE on lock high; at counter = LOCK_TIMEOUT_CYCLES-1 without lock, SHALL go to PLLRST and increment `retry_cnt`.
REQ-022 STABLE: lock low SHALL return to WAITLOCK and restart the counter; counter = LOCK_STABLE_CYCLES-1 with lock high SHALL go to DDRRST.
REQ-023 DDRRST: SHALL go to CALIB when counter = DDR_RST_CYCLES-1; lock low SHALL go to PLLRST.
REQ-024 CALIB: calibration high SHALL go to RUN; lock low SHALL go to PLLRST; lock loss takes priority over calibration in the same cycle.
REQ-025 RUN: lock low SHALL go to PLLRST and increment `lock_loss_cnt`; calibration low with lock high SHALL go to DDRRST.
REQ-026 Outputs SHALL be registered and decoded from the current state:
- `pll_rst` = (PLLRST)
- `ddr_rst` = not (CALIB or RUN)
- `sys_rst` = not RUN
- `ready` = RUN
REQ-027 `retry_cnt` and `lock_loss_cnt` SHALL saturate at 255 and never wrap.

Reset
REQ-028 On `rst` high at a `clk` edge, the block SHALL reset to:
- state = PLLRST and counter = 0
- `pll_rst` = `ddr_rst` = `sys_rst` = 1, `ready` = 0
- both event counters and synchronizers = 0
REQ-029 Reset mid-operation, including from RUN, SHALL restart the full sequence and SHALL NOT increment either event counter.

Configuration
REQ-030 With macro PLL_LOCK_RST_SEQ_CALIB_TIMEOUT_EN defined, CALIB at counter = CALIB_TIMEOUT_CYCLES-1 without calibration SHALL go to DDRRST and increment `retry_cnt`.
REQ-031 Without the macro, CALIB SHALL wait indefinitely and CALIB_TIMEOUT_CYCLES SHALL be unused.

Verification
Common bench parameters: PLL_RST_CYCLES=4, LOCK_STABLE_CYCLES=8, DDR_RST_CYCLES=6, LOCK_TIMEOUT_CYCLES=20, CALIB_TIMEOUT_CYCLES=30.
REQ-032 Nominal: lock rises 10 cycles after reset release and calibration rises 5 cycles after `ddr_rst` falls -> `pll_rst` high exactly 4 cycles, `ddr_rst` falls after 8 stable + 6 cycles, `ready`=1 and `sys_rst`=0 in RUN, both counters 0.
REQ-033 Lock glitch: lock goes low for 1 cycle at STABLE counter=5 -> returns to WAITLOCK, and DDRRST is entered only after 8 fresh consecutive lock cycles.
REQ-034 Lock never asserted for 100 cycles -> `pll_rst` pulses every 4+20 cycles and `retry_cnt`=4 after 4 timeouts.
REQ-035 Lock drops in RUN -> next state PLLRST, `ready`=0, `sys_rst`=1, `lock_loss_cnt`=1; repeated 300 times -> `lock_loss_cnt`=255.
REQ-036 Calibration never asserts: with the macro, 30 CALIB cycles -> DDRRST and `retry_cnt`+1; without the macro, remains in CALIB for 1000 cycles.
REQ-037 Simultaneous lock loss and calibration rising in CALIB -> next state PLLRST, not RUN.
